// File: rtl/noc_pkt_pkg.sv
// Shared definitions for the NoC local egress packetizer: routing header
// layout, header builder and packetizer FSM states.
package noc_pkt_pkg;

  localparam int PKT_BW        = 32;
  localparam int PKT_XY_SZ     = 3;
  localparam int PKT_OFFSET_SZ = 12;

  localparam int HDR_DST_LSB = 0;
  localparam int HDR_SRC_LSB = 2 * PKT_XY_SZ;
  localparam int HDR_LEN_LSB = 4 * PKT_XY_SZ;
  localparam int HDR_RSVD_W  = PKT_BW - HDR_LEN_LSB - PKT_OFFSET_SZ;

  // Field order is MSB first, so dst_x lands at bit 0.
  typedef struct packed {
    logic [HDR_RSVD_W-1:0]    rsvd;
    logic [PKT_OFFSET_SZ-1:0] len;
    logic [PKT_XY_SZ-1:0]     src_y;
    logic [PKT_XY_SZ-1:0]     src_x;
    logic [PKT_XY_SZ-1:0]     dst_y;
    logic [PKT_XY_SZ-1:0]     dst_x;
  } hdr_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2
  } pkt_state_e;

  function automatic hdr_t mk_hdr(input logic [2*PKT_XY_SZ-1:0] dst,
                                  input logic [2*PKT_XY_SZ-1:0] src,
                                  input logic [PKT_OFFSET_SZ-1:0] len);
    hdr_t h;
    h       = '0;
    h.dst_x = dst[PKT_XY_SZ-1:0];
    h.dst_y = dst[2*PKT_XY_SZ-1:PKT_XY_SZ];
    h.src_x = src[PKT_XY_SZ-1:0];
    h.src_y = src[2*PKT_XY_SZ-1:PKT_XY_SZ];
    h.len   = len;
    return h;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry stream register slice: outputs come straight from flops and
// in_ready depends only on local state, never on out_ready.
module axis_skid_buffer #(
  parameter int W = 37
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] main_data_r;
  logic         main_valid_r;
  logic [W-1:0] skid_data_r;
  logic         skid_valid_r;
  logic         push_s;
  logic         pop_s;

  assign in_ready  = ~skid_valid_r;
  assign out_valid = main_valid_r;
  assign out_data  = main_data_r;
  assign push_s    = in_valid & ~skid_valid_r;
  assign pop_s     = main_valid_r & out_ready;

  // Main/skid register update; the skid entry only fills when main is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_data_r  <= '0;
      main_valid_r <= 1'b0;
      skid_data_r  <= '0;
      skid_valid_r <= 1'b0;
    end else if (skid_valid_r) begin
      if (pop_s) begin
        main_data_r  <= skid_data_r;
        skid_valid_r <= 1'b0;
      end
    end else if (push_s) begin
      if (!main_valid_r || pop_s) begin
        main_data_r  <= in_data;
        main_valid_r <= 1'b1;
      end else begin
        skid_data_r  <= in_data;
        skid_valid_r <= 1'b1;
      end
    end else if (pop_s) begin
      main_valid_r <= 1'b0;
    end
  end

endmodule

// File: rtl/noc_local_egress_packetizer.sv
// Wraps accelerator bursts into NoC packets: one routing header flit, a
// length-bounded payload with forced TLAST, and a registered switch-side port.
module noc_local_egress_packetizer
  import noc_pkt_pkg::*;
#(
  parameter int BW        = PKT_BW,
  parameter int BWB       = BW / 8,
  parameter int XY_SZ     = PKT_XY_SZ,
  parameter int OFFSET_SZ = PKT_OFFSET_SZ
) (
  input  logic                 clk_line,
  input  logic                 clk_line_rst_high,
  input  logic [2*XY_SZ-1:0]   HsrcId,
  input  logic                 cfg_en,
  input  logic [2*XY_SZ-1:0]   cfg_dst,
  input  logic [OFFSET_SZ-1:0] cfg_len,
  input  logic                 err_clr,
  input  logic                 s_TVALID,
  input  logic [BW-1:0]        s_TDATA,
  input  logic [BWB-1:0]       s_TKEEP,
  input  logic                 s_TLAST,
  output logic                 s_TREADY,
  output logic                 m_TVALID,
  output logic [BW-1:0]        m_TDATA,
  output logic [BWB-1:0]       m_TKEEP,
  output logic                 m_TLAST,
  input  logic                 m_TREADY,
  output logic                 busy,
  output logic [15:0]          pkt_count,
  output logic                 err_short
);

  localparam int SW = BW + BWB + 1;
  localparam logic [OFFSET_SZ-1:0] LEN_ONE = OFFSET_SZ'(1);

  pkt_state_e           state_r;
  pkt_state_e           next_state_s;
  logic [2*XY_SZ-1:0]   dst_r;
  logic [OFFSET_SZ-1:0] len_r;
  logic [OFFSET_SZ-1:0] cnt_r;
  logic [15:0]          pkt_count_r;
  logic                 err_short_r;

  logic                 start_s;
  logic                 accept_s;
  logic                 len_hit_s;
  logic                 last_s;
  logic                 short_s;
  logic                 s_ready_s;
  hdr_t                 hdr_s;
  logic [BW-1:0]        hdr_word_s;

  logic                 skid_in_valid_s;
  logic                 skid_in_ready_s;
  logic [SW-1:0]        skid_in_data_s;
  logic                 skid_out_valid_s;
  logic [SW-1:0]        skid_out_data_s;

  assign hdr_s      = mk_hdr(dst_r, HsrcId, len_r);
  assign hdr_word_s = BW'(hdr_s);
  assign start_s    = s_TVALID & cfg_en;
  assign accept_s   = (state_r == PAYLOAD) & s_TVALID & skid_in_ready_s;
  // len_r == 0 means the packet is bounded by the input TLAST alone.
  assign len_hit_s  = (len_r != '0) && (cnt_r == (len_r - LEN_ONE));
  assign last_s     = s_TLAST | len_hit_s;
  assign short_s    = s_TLAST && (len_r != '0) && (cnt_r < (len_r - LEN_ONE));

  // Next-state logic and the header/payload mux feeding the skid buffer.
  always_comb begin
    next_state_s    = state_r;
    s_ready_s       = 1'b0;
    skid_in_valid_s = 1'b0;
    skid_in_data_s  = {1'b0, {BWB{1'b1}}, hdr_word_s};
    case (state_r)
      IDLE: begin
        if (start_s) begin
          next_state_s = HDR;
        end else begin
          next_state_s = IDLE;
        end
      end
      HDR: begin
        skid_in_valid_s = 1'b1;
        if (skid_in_ready_s) begin
          next_state_s = PAYLOAD;
        end else begin
          next_state_s = HDR;
        end
      end
      PAYLOAD: begin
        s_ready_s       = skid_in_ready_s;
        skid_in_valid_s = s_TVALID;
        skid_in_data_s  = {last_s, s_TKEEP, s_TDATA};
        if (accept_s && last_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = PAYLOAD;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // FSM state, latched packet config, word counter, packet counter, error flag.
  always_ff @(posedge clk_line) begin
    if (clk_line_rst_high) begin
      state_r     <= IDLE;
      dst_r       <= '0;
      len_r       <= '0;
      cnt_r       <= '0;
      pkt_count_r <= 16'd0;
      err_short_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if ((state_r == IDLE) && start_s) begin
        dst_r <= cfg_dst;
        len_r <= cfg_len;
        cnt_r <= '0;
      end else if (accept_s) begin
        cnt_r <= cnt_r + LEN_ONE;
      end
      if (accept_s && last_s) begin
        pkt_count_r <= pkt_count_r + 16'd1;
      end
      // A new short-packet event takes priority over a same-cycle clear.
      if (accept_s && short_s) begin
        err_short_r <= 1'b1;
      end else if (err_clr) begin
        err_short_r <= 1'b0;
      end
    end
  end

  axis_skid_buffer #(.W(SW)) u_skid (
    .clk       (clk_line),
    .rst       (clk_line_rst_high),
    .in_data   (skid_in_data_s),
    .in_valid  (skid_in_valid_s),
    .in_ready  (skid_in_ready_s),
    .out_data  (skid_out_data_s),
    .out_valid (skid_out_valid_s),
    .out_ready (m_TREADY)
  );

  assign s_TREADY  = s_ready_s;
  assign m_TVALID  = skid_out_valid_s;
  assign m_TLAST   = skid_out_data_s[SW-1];
  assign m_TKEEP   = skid_out_data_s[BW+BWB-1:BW];
  assign m_TDATA   = skid_out_data_s[BW-1:0];
  assign busy      = (state_r != IDLE) | skid_out_valid_s | ~skid_in_ready_s;
  assign pkt_count = pkt_count_r;
  assign err_short = err_short_r;

endmodule
